// File: rtl/cflog_drain_if.sv
// Log-write and transport-stream bundle between the CFA monitor/transport (master) and cflog_drain (slave).
interface cflog_drain_if;
    logic        cflow_hw_wen;
    logic [15:0] cflow_log_ptr;
    logic [15:0] cflow_src;
    logic [15:0] cflow_dest;
    logic        flush;
    logic        tx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;

    modport master (
        output cflow_hw_wen, cflow_log_ptr, cflow_src, cflow_dest, flush, tx_ready,
        input  tx_valid, tx_data
    );

    modport slave (
        input  cflow_hw_wen, cflow_log_ptr, cflow_src, cflow_dest, flush, tx_ready,
        output tx_valid, tx_data
    );
endinterface

// File: rtl/cflog_drain.sv
// CF-Log buffer: stores src/dest pairs, drains header + words on flush; header 1 cycle after flush.
// Stream holds tx_data while stalled; writes arriving outside IDLE are dropped and flagged in ovf.
module cflog_drain #(
    parameter int LOG_SIZE = 16'h0100,
    parameter int IDX_W    = 8
) (
    input  logic          clk_i,
    input  logic          puc_i,
    cflog_drain_if.slave  bus,
    output logic          drain_busy_o,
    output logic          drain_done_o,
    output logic          ovf_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [15:0]    mem_q [LOG_SIZE];

    logic [1:0]     state_q, state_d;
    logic [IDX_W:0] hwm_q, hwm_d;
    logic [IDX_W:0] cnt_q, cnt_d;
    logic [IDX_W:0] rd_q, rd_d;
    logic           ovf_q, ovf_d;
    logic           armed_q, armed_d;
    logic           tx_valid_q, tx_valid_d;
    logic [15:0]    tx_data_q, tx_data_d;
    logic           done_q, done_d;

    logic           idle;
    logic [16:0]    ptr_end;
    logic           in_range;
    logic           wr_acc;
    logic           wr_drop;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W:0] wr_end;
    logic [IDX_W:0] hwm_nxt;
    logic           ovf_nxt;
    logic           hs;
    logic           start;

    assign idle     = (state_q == S_IDLE);
    // 17-bit compare so a pointer near 0xFFFF cannot wrap into range
    assign ptr_end  = {1'b0, bus.cflow_log_ptr} + 17'd2;
    assign in_range = (ptr_end <= 17'(LOG_SIZE));
    assign wr_acc   = bus.cflow_hw_wen & idle & in_range;
    assign wr_drop  = bus.cflow_hw_wen & ~wr_acc;
    assign wr_idx   = bus.cflow_log_ptr[IDX_W-1:0];
    assign wr_end   = ptr_end[IDX_W:0];
    assign hwm_nxt  = (wr_acc && (wr_end > hwm_q)) ? wr_end : hwm_q;
    assign ovf_nxt  = ovf_q | wr_drop;
    assign hs       = tx_valid_q & bus.tx_ready;
    assign start    = bus.flush & armed_q & idle;

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_idx]               <= bus.cflow_src;
            mem_q[wr_idx + IDX_W'(1)]   <= bus.cflow_dest;
        end
    end

    always_comb begin
        state_d    = state_q;
        hwm_d      = hwm_nxt;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        ovf_d      = ovf_nxt;
        armed_d    = bus.flush ? armed_q : 1'b1;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    armed_d    = 1'b0;
                    cnt_d      = hwm_nxt;
                    tx_data_d  = {ovf_nxt, 15'(hwm_nxt)};
                    tx_valid_d = 1'b1;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (hs) begin
                    // a drop in the same cycle as the header handshake must survive
                    ovf_d = wr_drop;
                    if (cnt_q == '0) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        rd_d      = (IDX_W+1)'(1);
                        tx_data_d = mem_q[0];
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (rd_q == cnt_q) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        tx_data_d = mem_q[rd_q[IDX_W-1:0]];
                        rd_d      = rd_q + (IDX_W+1)'(1);
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                hwm_d   = '0;
                rd_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (puc_i) begin
            state_q    <= S_IDLE;
            hwm_q      <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hwm_q      <= hwm_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            ovf_q      <= ovf_d;
            armed_q    <= armed_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign drain_busy_o  = ~idle;
    assign drain_done_o  = done_q;
    assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_cflog_drain.sv
// Directed bench for cflog_drain: expected stream words are queued by stimulus and popped by a monitor.
module tb_cflog_drain;
    logic clk;
    logic puc;
    logic drain_busy, drain_done, ovf;

    cflog_drain_if bus();

    cflog_drain #(.LOG_SIZE(16'h0100), .IDX_W(8)) dut (
        .clk_i        (clk),
        .puc_i        (puc),
        .bus          (bus),
        .drain_busy_o (drain_busy),
        .drain_done_o (drain_done),
        .ovf_o        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_hs = -100;
    logic [15:0] exp_q[$];
    logic        stall_chk = 1'b0;
    logic [15:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a negedge sample of valid&ready predicts the handshake at the next posedge.
    always @(negedge clk) begin
        if (puc) begin
            stall_chk = 1'b0;
        end else begin
            if (stall_chk) begin
                chk("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
                chk("stall_data", {16'd0, bus.tx_data}, {16'd0, held});
            end
            stall_chk = bus.tx_valid && !bus.tx_ready;
            held      = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("stream_word", {16'd0, bus.tx_data}, {16'd0, e});
                end
                last_hs = cyc;
            end
            if (drain_done) begin
                done_cnt++;
                chk("done_timing", cyc - last_hs, 32'd2);
                chk("done_queue_empty", exp_q.size(), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] ptr, input logic [15:0] src, input logic [15:0] dst);
        bus.cflow_hw_wen  = 1'b1;
        bus.cflow_log_ptr = ptr;
        bus.cflow_src     = src;
        bus.cflow_dest    = dst;
        tick();
        bus.cflow_hw_wen  = 1'b0;
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'd0, done_cnt == start_cnt}, 32'd0);
    endtask

    initial begin
        logic [15:0] pat;
        int n, d0;
        pat = 16'b0110_1001_0011_0100;
        puc = 1'b1;
        bus.cflow_hw_wen  = 1'b0;
        bus.cflow_log_ptr = '0;
        bus.cflow_src     = '0;
        bus.cflow_dest    = '0;
        bus.flush         = 1'b0;
        bus.tx_ready      = 1'b1;
        repeat (3) tick();
        puc = 1'b0;
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data", {16'd0, bus.tx_data}, 32'd0);
        chk("rst_busy", {31'd0, drain_busy}, 32'd0);
        chk("rst_done", {31'd0, drain_done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // Three entries, last one written in the same cycle as flush
        wr(16'h0000, 16'hE100, 16'hE200);
        wr(16'h0002, 16'hE101, 16'hE201);
        exp_q.push_back(16'h0006);
        exp_q.push_back(16'hE100); exp_q.push_back(16'hE200);
        exp_q.push_back(16'hE101); exp_q.push_back(16'hE201);
        exp_q.push_back(16'hE102); exp_q.push_back(16'hE202);
        bus.cflow_hw_wen = 1'b1; bus.cflow_log_ptr = 16'h0004;
        bus.cflow_src = 16'hE102; bus.cflow_dest = 16'hE202;
        bus.flush = 1'b1;
        tick();
        bus.cflow_hw_wen = 1'b0; bus.flush = 1'b0;
        chk("hdr_valid_n1", {31'd0, bus.tx_valid}, 32'd1);
        chk("busy_n1", {31'd0, drain_busy}, 32'd1);
        wait_done(50);

        // Empty drain: also proves hwm was cleared
        exp_q.push_back(16'h0000);
        flush_pulse();
        wait_done(20);

        // Full buffer, then two out-of-range writes (one would wrap at 16 bits)
        for (int i = 0; i < 128; i++)
            wr(16'(2*i), 16'(16'h3000 + 2*i), 16'(16'h3001 + 2*i));
        wr(16'h0100, 16'hDEAD, 16'hBEEF);
        wr(16'hFFFF, 16'hDEAD, 16'hBEEF);
        chk("ovf_after_drop", {31'd0, ovf}, 32'd1);
        exp_q.push_back(16'h8100);
        for (int k = 0; k < 256; k++) exp_q.push_back(16'(16'h3000 + k));
        flush_pulse();
        wait_done(600);
        chk("ovf_cleared_full", {31'd0, ovf}, 32'd0);

        // Backpressure with a fixed irregular ready pattern
        wr(16'h0000, 16'hA001, 16'hA002);
        wr(16'h0002, 16'hA003, 16'hA004);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'hA001); exp_q.push_back(16'hA002);
        exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
        d0 = done_cnt;
        bus.tx_ready = 1'b0;
        flush_pulse();
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            bus.tx_ready = pat[n % 16];
            tick();
            n++;
        end
        bus.tx_ready = 1'b1;
        chk("bp_timeout", {31'd0, done_cnt == d0}, 32'd0);

        // Write during DATA with flush held high through completion
        wr(16'h0000, 16'hC0DE, 16'hC0DF);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'hC0DE); exp_q.push_back(16'hC0DF);
        bus.flush = 1'b1;
        tick();
        tick();
        wr(16'h0002, 16'h1111, 16'h2222);
        wait_done(20);
        repeat (5) tick();
        chk("no_retrigger_busy", {31'd0, drain_busy}, 32'd0);
        chk("no_retrigger_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("ovf_persists", {31'd0, ovf}, 32'd1);
        bus.flush = 1'b0;
        tick();
        exp_q.push_back(16'h8000);
        flush_pulse();
        wait_done(20);
        chk("ovf_cleared_rearm", {31'd0, ovf}, 32'd0);

        // Reset while in DATA
        wr(16'h0000, 16'h5551, 16'h5552);
        wr(16'h0002, 16'h5553, 16'h5554);
        exp_q.push_back(16'h0004);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        bus.tx_ready = 1'b0;
        puc = 1'b1;
        tick();
        chk("rst_mid_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, drain_busy}, 32'd0);
        chk("rst_mid_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_mid_done", {31'd0, drain_done}, 32'd0);
        puc = 1'b0;
        bus.tx_ready = 1'b1;
        d0 = done_cnt;
        repeat (4) tick();
        chk("rst_mid_no_done_pulse", done_cnt, d0);
        exp_q.push_back(16'h0000);
        flush_pulse();
        wait_done(20);

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cflog_drain.md
# cflog_drain

Downstream consumer of the CFA monitor's log-write outputs. It stores each logged control-flow pair (`cflow_src`, `cflow_dest`) into an internal CF-Log buffer at the word index given by `cflow_log_ptr`. When the monitor raises `flush`, it streams the buffered log out over a valid/ready word interface to the attestation transport, framed by a header word. It then reports completion and clears the buffer state for the next attestation window.

## Interface
- `LOG_SIZE`, `16'h0100`: buffer depth in 16-bit words; must be even and a power of two.
- `IDX_W`, `8`: `log2(LOG_SIZE)`; word index width.
- `clk`  in  1  system clock.
- `puc`  in  1  synchronous, active-high reset.
- `cflow_hw_wen`  in  1  log write strobe, one cycle per entry.
- `cflow_log_ptr`  in  16  word index of the entry's first word (even).
- `cflow_src`  in  16  entry word 0.
- `cflow_dest`  in  16  entry word 1.
- `flush`  in  1  drain request, level.
- `tx_ready`  in  1  transport accepts a word.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_data`  out  16  streamed word.
- `drain_busy`  out  1  high in any state except IDLE.
- `drain_done`  out  1  one-cycle pulse at the end of a drain.
- `ovf`  out  1  sticky: at least one entry was dropped since the last reported header.

## Operation
- Storage: `mem[0..LOG_SIZE-1]` of 16-bit words. There is no reset of the contents.
- Fill level: `hwm` is the number of valid words, width `IDX_W+1`.
- Write accept rule. A write is accepted when `cflow_hw_wen=1`, the state is IDLE, and `cflow_log_ptr+2 <= LOG_SIZE` (compare at 17 bits, no wrap). An accepted write does:
  - `mem[ptr] <= cflow_src`
  - `mem[ptr+1] <= cflow_dest`
  - `hwm <= max(hwm, ptr+2)`
- Dropped writes. If the write is out of range, or arrives in any non-IDLE state, the entry is dropped and `ovf <= 1`.
- Drain arming:
  - `armed` is set by reset and by any cycle with `flush=0`.
  - A drain starts only when `flush=1`, `armed=1`, and the state is IDLE.
  - Starting a drain clears `armed`, so `flush` held high after completion does not re-trigger.
- FSM states: IDLE, HDR, DATA, DONE.
- IDLE:
  - On drain start, latch `cnt <= hwm'`, where `hwm'` already includes a write accepted in the same cycle.
  - Load `tx_data <= {ovf', cnt[14:0]}` with `ovf'` likewise including that cycle's drop.
  - Set `tx_valid <= 1` and go to HDR.
- HDR, on handshake (`tx_valid & tx_ready`):
  - Clear `ovf` unless a drop occurs in the same cycle; a same-cycle drop wins and `ovf` stays 1.
  - If `cnt==0`: `tx_valid <= 0`, go to DONE.
  - Otherwise: `rd <= 1`, `tx_data <= mem[0]`, go to DATA.
- DATA, on handshake:
  - If `rd==cnt`: `tx_valid <= 0`, go to DONE.
  - Otherwise: `tx_data <= mem[rd]`, `rd <= rd+1`.
- DONE: `drain_done <= 1` for one cycle, `hwm <= 0`, `rd <= 0`, go to IDLE.
- Handshake rules:
  - `tx_data` is stable while `tx_valid=1 & tx_ready=0`.
  - `tx_valid` never drops without a handshake.
  - Throughput is one word per cycle when `tx_ready` is held high.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0`, `drain_busy=0`, `drain_done=0`, `ovf=0`; also `hwm=0`, `armed=1`, state IDLE.
- Write latency: a write strobed in cycle N is readable by the drain from cycle N+1.
- Drain start: `flush` sampled high in IDLE at cycle N gives the header on `tx_valid` at N+1 and `drain_busy=1` at N+1.
- Word sequence: header, then `cnt` data words. With continuous ready, the last data handshake is at cycle N+1+cnt.
- Completion: `drain_done` pulses 2 cycles after the last handshake (DONE state registered). The next drain is possible after `flush` has been low for 1 cycle.
- Same-cycle write and flush in IDLE: the write is accepted and counted in the header.
- Reset mid-drain: the FSM returns to IDLE next cycle with `tx_valid=0`, `hwm=0`, and no `drain_done` pulse.
- Full buffer: `ptr=LOG_SIZE-2` is accepted, giving `hwm=LOG_SIZE`. `ptr>=LOG_SIZE-1` is dropped and sets `ovf`.

## Test plan
- Write three entries at ptr 0, 2, 4 (src/dest `0xE100/0xE200`, …), pulse flush, tx_ready=1.
  - Stream `0x0006`, then the 6 words in order.
  - `drain_done` 2 cycles after the last word; `hwm` back to 0.
- No writes, then flush.
  - Header `0x0000` only, then `drain_done`.
- Fill to ptr `0x00FE`, then write at ptr `0x0100`.
  - Header `0x8100`, 256 data words; `ovf=0` after the header handshake.
- Random `tx_ready` backpressure (~50% duty) during a 4-word drain.
  - `tx_data` stable while stalled; the full sequence is intact.
- Write during DATA, and hold `flush` high through DONE.
  - The entry is dropped and `ovf=1` persists to the next header.
  - No second drain until `flush` goes low then high.
- Assert `puc` while in DATA.
  - Next cycle: `tx_valid=0`, `drain_busy=0`, `ovf=0`, no `drain_done`.
  - A subsequent flush gives header `0x0000`.
